bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared memory port.
// Write completions are broadcast on the snoop outputs for coherence.
module bus_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              wr_a,
    input  logic              wr_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              snoop_valid,
    output logic              snoop_src,
    output logic [ADDR_W-1:0] snoop_addr
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            r_state;
    logic              r_prio;
    logic              r_owner;
    logic              r_wr;
    logic              r_gnt_a;
    logic              r_gnt_b;
    logic              r_ack_a;
    logic              r_ack_b;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_snoop_valid;
    logic              r_snoop_src;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_snoop_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;

    logic              w_pick_b;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // B wins when it asks alone, or when both ask and the pointer favours B.
    assign w_pick_b    = req_b & (~req_a | r_prio);
    assign w_sel_wr    = w_pick_b ? wr_b    : wr_a;
    assign w_sel_addr  = w_pick_b ? addr_b  : addr_a;
    assign w_sel_wdata = w_pick_b ? wdata_b : wdata_a;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_prio        <= 1'b0;
            r_owner       <= 1'b0;
            r_wr          <= 1'b0;
            r_gnt_a       <= 1'b0;
            r_gnt_b       <= 1'b0;
            r_ack_a       <= 1'b0;
            r_ack_b       <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_snoop_valid <= 1'b0;
            r_snoop_src   <= 1'b0;
            r_mem_addr    <= '0;
            r_snoop_addr  <= '0;
            r_mem_wdata   <= '0;
            r_rdata_a     <= '0;
            r_rdata_b     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_a || req_b) begin
                        r_state     <= BUSY;
                        r_owner     <= w_pick_b;
                        r_wr        <= w_sel_wr;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_read  <= ~w_sel_wr;
                        r_mem_write <= w_sel_wr;
                        r_gnt_a     <= ~w_pick_b;
                        r_gnt_b     <= w_pick_b;
                    end
                end
                BUSY: begin
                    // Command stays on the bus, untouched by any input, until memory answers.
                    if (mem_ready) begin
                        r_state       <= RESP;
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_snoop_valid <= r_wr;
                        if (r_owner) begin
                            r_rdata_b <= mem_rdata;
                            r_ack_b   <= 1'b1;
                        end else begin
                            r_rdata_a <= mem_rdata;
                            r_ack_a   <= 1'b1;
                        end
                        if (r_wr) begin
                            r_snoop_src  <= r_owner;
                            r_snoop_addr <= r_mem_addr;
                        end
                    end
                end
                RESP: begin
                    r_state       <= IDLE;
                    r_ack_a       <= 1'b0;
                    r_ack_b       <= 1'b0;
                    r_snoop_valid <= 1'b0;
                    r_gnt_a       <= 1'b0;
                    r_gnt_b       <= 1'b0;
                    r_prio        <= ~r_owner;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt_a       = r_gnt_a;
    assign gnt_b       = r_gnt_b;
    assign ack_a       = r_ack_a;
    assign ack_b       = r_ack_b;
    assign rdata_a     = r_rdata_a;
    assign rdata_b     = r_rdata_b;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign snoop_valid = r_snoop_valid;
    assign snoop_src   = r_snoop_src;
    assign snoop_addr  = r_snoop_addr;

endmodule
